// File: rtl/wave_rom_arbiter_if.sv
// wave_rom_arbiter_if: channel request/grant, ROM port B and tagged read-return bundle
interface wave_rom_arbiter_if #(
   parameter int NCH = 8,
   parameter int AW  = 17,
   parameter int DW  = 8
);
   logic [NCH-1:0]    ch_req;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH-1:0]    ch_gnt;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_q;
   logic              rd_valid;
   logic [2:0]        rd_chan;
   logic [DW-1:0]     rd_data;

   modport master (
      output ch_req, ch_addr, rom_q,
      input  ch_gnt, rom_addr, rd_valid, rd_chan, rd_data
   );

   modport slave (
      input  ch_req, ch_addr, rom_q,
      output ch_gnt, rom_addr, rd_valid, rd_chan, rd_data
   );
endinterface

// File: rtl/wave_rom_arbiter.sv
// wave_rom_arbiter: round-robin sharing of the wave ROM read port between DMA sound channels
module wave_rom_arbiter #(
   parameter int NCH = 8,
   parameter int AW  = 17,
   parameter int DW  = 8
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   wave_rom_arbiter_if.slave bus
);
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic             lock_q, lock_d;
   logic             issue_v_q, issue_v_d;
   logic [2:0]       issue_ch_q, issue_ch_d;
   logic             rd_valid_q, rd_valid_d;
   logic [2:0]       rd_chan_q, rd_chan_d;
   logic [NCH-1:0]   gnt_q, gnt_d;
   logic [AW-1:0]    rom_addr_q, rom_addr_d;
   logic [NCH-1:0]   elig;
   logic [2*NCH-1:0] rot;
   logic [2:0]       off;
   logic [3:0]       sum;
   logic             win_v;
   logic [2:0]       win;
   logic [AW-1:0]    win_addr;
   logic             arb_en;
   logic [DW-1:0]    rd_data_w;

   // first eligible channel at or after rr_ptr; doubling the mask makes the wrap fall at NCH
   always_comb begin
      elig = bus.ch_req & ~gnt_q;
      rot = {elig, elig} >> rr_ptr_q;
      win_v = 1'b0;
      off = 3'd0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (rot[k]) begin
            win_v = 1'b1;
            off = 3'(k);
         end
      end
      sum = {1'b0, rr_ptr_q} + {1'b0, off};
      win = (sum >= 4'(NCH)) ? 3'(sum - 4'(NCH)) : sum[2:0];
   end

   // address of the winning channel
   always_comb begin
      win_addr = '0;
      for (int k = 0; k < NCH; k++) begin
         if (win == 3'(k)) win_addr = bus.ch_addr[k*AW +: AW];
      end
   end

   // grant/issue decision; lock mirrors the loader one cycle late so the edge after it drops stays idle
   always_comb begin
      lock_d = ioctl_download;
      arb_en = !ioctl_download && !lock_q;
      gnt_d = (arb_en && win_v) ? (NCH'(1) << win) : '0;
      issue_v_d = arb_en && win_v;
      issue_ch_d = (arb_en && win_v) ? win : issue_ch_q;
      rom_addr_d = (arb_en && win_v) ? win_addr : rom_addr_q;
      rr_ptr_d = !(arb_en && win_v) ? rr_ptr_q : (win == 3'(NCH - 1)) ? 3'd0 : win + 3'd1;
      rd_valid_d = issue_v_q;
      rd_chan_d = issue_ch_q;
   end

   // state registers; reset drops any read still in flight
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         issue_v_q  <= 1'b0;
         issue_ch_q <= '0;
         rd_valid_q <= 1'b0;
         rd_chan_q  <= '0;
         gnt_q      <= '0;
         rom_addr_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         issue_v_q  <= issue_v_d;
         issue_ch_q <= issue_ch_d;
         rd_valid_q <= rd_valid_d;
         rd_chan_q  <= rd_chan_d;
         gnt_q      <= gnt_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   assign rd_data_w    = bus.rom_q;
   assign bus.rd_data  = rd_data_w;
   assign bus.ch_gnt   = gnt_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_chan  = rd_chan_q;
endmodule
